// File: rtl/fetch_inst_queue_pkg.sv
// rtl/fetch_inst_queue_pkg.sv - shared fetch packet type and queue defaults
package cpu_fetch_pkg;

  localparam int FQ_ADDR_W        = 32;
  localparam int FQ_INST_W        = 32;
  localparam int FQ_DEPTH_DEFAULT = 4;

  // One fetched instruction as it travels from fetch to decode.
  typedef struct packed {
    logic [FQ_ADDR_W-1:0] pc;
    logic [FQ_INST_W-1:0] inst;
    logic                 pred;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_inst_queue_if.sv
// rtl/fetch_inst_queue_if.sv - fetch/decode handshake bundle for the instruction queue
interface fetch_inst_queue_if #(
  parameter int ADDR  = 32,
  parameter int INST  = 32,
  parameter int DEPTH = 4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [ADDR-1:0]  in_pc;
  logic [INST-1:0]  in_inst;
  logic             in_pred;
  logic             out_valid;
  logic             out_ready;
  logic [ADDR-1:0]  out_pc;
  logic [INST-1:0]  out_inst;
  logic             out_pred;
  logic [CNT_W-1:0] count;

  // Pipeline side: fetch offers packets, decode consumes them, redirect flushes.
  modport master (
    output flush, in_valid, in_pc, in_inst, in_pred, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_pred, count
  );

  // Queue side.
  modport slave (
    input  flush, in_valid, in_pc, in_inst, in_pred, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_pred, count
  );

endinterface

// File: rtl/fetch_inst_queue.sv
// rtl/fetch_inst_queue.sv - in-order decoupling queue between fetch and decode
module fetch_inst_queue
  import cpu_fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  fetch_inst_queue_if.slave fq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fetch_pkt_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, wr_en;
  fetch_pkt_t       wr_pkt;

  // Handshake status comes only from registered occupancy, so in_ready never
  // depends on out_ready and a full queue cannot accept in the same cycle it drains.
  assign fq.in_ready  = (count_q != CNT_FULL);
  assign fq.out_valid = (count_q != '0);
  assign fq.count     = count_q;
  assign fq.out_pc    = mem_q[rd_ptr_q].pc;
  assign fq.out_inst  = mem_q[rd_ptr_q].inst;
  assign fq.out_pred  = mem_q[rd_ptr_q].pred;

  assign push = fq.in_valid & fq.in_ready;
  assign pop  = fq.out_valid & fq.out_ready;

  assign wr_pkt = '{pc: fq.in_pc, inst: fq.in_inst, pred: fq.in_pred};

  // Next pointer/occupancy; flush overrides any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    if (fq.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_pkt;
    end
  end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb/tb_fetch_inst_queue.sv - directed scoreboard bench for fetch_inst_queue
module tb_fetch_inst_queue;
  import cpu_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  fetch_inst_queue_if #(.ADDR(32), .INST(32), .DEPTH(DEPTH)) bus ();

  fetch_inst_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (bus.slave)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fetch_pkt_t sb[$];
  int         mc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Check the state left by the previous edge against the model, then drive
  // this cycle's inputs and advance the model to what the next edge must produce.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic pred, input logic rdy, input logic fl);
    logic do_push, do_pop;
    fetch_pkt_t p;
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 32'(mc != 0));
    chk("in_ready",  32'(bus.in_ready),  32'(mc != DEPTH));
    chk("count",     32'(bus.count),     32'(mc));
    chk("occupancy_bound", 32'(bus.count <= DEPTH), 32'd1);
    if (mc != 0) begin
      chk("out_pc",   bus.out_pc,          sb[0].pc);
      chk("out_inst", bus.out_inst,        sb[0].inst);
      chk("out_pred", 32'(bus.out_pred),   32'(sb[0].pred));
    end
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.in_pred   = pred;
    bus.out_ready = rdy;
    bus.flush     = fl;
    do_push = v && (mc != DEPTH);
    do_pop  = rdy && (mc != 0);
    if (fl) begin
      sb.delete();
      mc = 0;
    end else begin
      if (do_pop) begin
        void'(sb.pop_front());
        mc--;
      end
      if (do_push) begin
        p = '{pc: pc, inst: inst, pred: pred};
        sb.push_back(p);
        mc++;
      end
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 32'h0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_inst   = '0;
    bus.in_pred   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_count",     32'(bus.count),     32'd0);
    chk("rst_out_pc",    bus.out_pc,         32'd0);
    chk("rst_out_inst",  bus.out_inst,       32'd0);
    chk("rst_out_pred",  32'(bus.out_pred),  32'd0);
    reset = 1'b0;

    // Fill to full, then a fifth push is refused
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), i[0], 1'b0, 1'b0);
    step(1'b1, 32'h110, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    // Drain; the first pop from full also offers a packet that must not be taken
    step(1'b1, 32'h110, 32'hBEEF, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    idle(1'b0);

    // Streaming at occupancy 1 across many pointer wraps
    step(1'b1, 32'h200, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) step(1'b1, 32'h200 + 32'(4 * i), 32'(i), 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Flush with a simultaneous push and pop
    for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(4 * i), 32'h50 + 32'(i), 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h300, 32'h30, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h600, 32'h60, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // No bypass: a push into an empty queue shows up only after the edge
    step(1'b1, 32'h400, 32'h40, 1'b1, 1'b0, 1'b0);
    #1 chk("nobypass_out_valid", 32'(bus.out_valid), 32'd0);
    idle(1'b1);
    idle(1'b0);

    // Asynchronous reset with two entries queued
    step(1'b1, 32'h700, 32'h70, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h704, 32'h71, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    #1 reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_count",     32'(bus.count),     32'd0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("arst_out_pc",    bus.out_pc,         32'd0);
    sb.delete();
    mc = 0;
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 32'h800, 32'h80, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
